seg7_readback_checker: RTL and testbench
========================================

// Module: seg7_readback_checker
// PURPOSE
//  Loopback monitor for the single-digit 7-segment display path. Samples the physical
//  segment lines (a..g, dp), decodes them back to a hex digit, and confirms the display
//  advances by exactly +1 (mod 16) on every clk1s tick. Flags stalls, skips, illegal
//  patterns and counter restarts. Sits beside the display counter in the same clk1s domain.
// PARAMETERS
//  ACTIVE_LOW  1  1: seg_n is common-anode (segment lit = 0); 0: lit = 1
//  SYNC_COUNT  2  consecutive correct +1 steps needed to enter LOCK (range 1..7)
//  ERR_W       8  width of saturating error counter
// PORTS
//  clk1s      in   1      1 Hz tick clock; all logic on posedge
//  reset      in   1      asynchronous, active-low
//  seg_n      in   8      segment lines: [0]=a [1]=b [2]=c [3]=d [4]=e [5]=f [6]=g [7]=dp
//  digit      out  4      last decoded digit
//  digit_ok   out  1      digit holds a legal pattern
//  locked     out  1      FSM in LOCK
//  mismatch   out  1      one-cycle pulse: sequence error detected
//  restart    out  1      one-cycle pulse: display jumped to 0 (counter reset seen)
//  dp_seen    out  1      sticky: dp lit at any sample since reset
//  err_count  out  ERR_W  saturating count of mismatch pulses
// BEHAVIOUR
//  - Reset (reset=0, async): all outputs 0, state HUNT, internal sample/step regs 0.
//  - Stage 1: seg_q <= ACTIVE_LOW ? ~seg_n : seg_n (one register, no sync chain; same domain).
//  - Decode (comb, on seg_q[6:0]; dp masked): gfedcba hex 0..F =
//    3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71. Any other pattern -> illegal.
//  - Stage 2 (registered): digit <= decoded value (held unchanged if illegal);
//    digit_ok <= legal. Latency seg_n -> digit/digit_ok = 2 clk1s edges.
//  - dp_seen <= dp_seen | seg_q[7].
//  - "step good": legal AND decoded == digit_prev + 1 (4-bit wrap; F->0 is good).
//    digit_prev is digit before this edge; first legal sample after HUNT only seeds it.
//  - FSM (updates on same edge as stage 2; pulses coincide with offending digit):
//    HUNT: legal -> SYNC, step_cnt=0. Illegal -> stay.
//    SYNC: good -> step_cnt++; when step_cnt reaches SYNC_COUNT -> LOCK.
//          legal not good -> step_cnt=0, stay (reseed). Illegal -> HUNT. No pulses in SYNC.
//    LOCK: good -> stay. Legal 0 while expected !=0 -> restart=1, SYNC, step_cnt=0.
//          Other legal wrong value (incl. stall: same digit) -> mismatch=1, SYNC, step_cnt=0.
//          Illegal -> mismatch=1, HUNT.
//  - locked = (state==LOCK), registered.
//  - err_count increments on each mismatch; saturates at all-ones, never wraps.
//  - mismatch and restart never both 1. Pulses last exactly one cycle.
//  - Async reset mid-operation: immediate clear, no pulse generated.
// STRUCTURE
//  - seg7_pkg: segment bit indices, 16 hex pattern constants, FSM state encoding
//    (HUNT=2'd0, SYNC=2'd1, LOCK=2'd2).
//  - Sub-module seg7_decode: combinational seg[6:0] -> {legal, digit[3:0]}; inverse of the
//    display's digit-to-segment encoder, reusable for other readback paths.
//  - Top: input register, stage-2 regs, FSM, step counter, error counter.
// TESTING
//  1. Reset, drive active-low patterns 0,1,2,3,4 -> locked=1 at digit=2 (SYNC_COUNT=2), no pulses.
//  2. Locked, drive ...E,F,0,1 -> wrap accepted, locked stays 1, err_count=0.
//  3. Locked at 5, drive 5 again (stall) -> mismatch=1 one cycle, err_count=1, locked=0; then
//     6,7 -> locked=1.
//  4. Locked at 9, drive 0 -> restart=1, mismatch=0, err_count unchanged; 1,2 -> relock.
//  5. Locked, drive seg_n=8'hFF (all dark) -> mismatch=1, digit_ok=0, state HUNT, digit held.
//  6. Drive dp low once with digit 3 -> dp_seen=1 stays; err_count at 8'hFF + mismatch
//     -> stays 8'hFF; assert reset mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for 7-segment readback: segment bit positions, the hex
// glyph table (gfedcba) and the checker FSM encoding.
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_t;

  // Lit-segment glyph for each hex digit, bit order gfedcba.
  function automatic logic [6:0] hex_pat(input logic [3:0] d);
    case (d)
      4'h0: hex_pat = 7'h3F;
      4'h1: hex_pat = 7'h06;
      4'h2: hex_pat = 7'h5B;
      4'h3: hex_pat = 7'h4F;
      4'h4: hex_pat = 7'h66;
      4'h5: hex_pat = 7'h6D;
      4'h6: hex_pat = 7'h7D;
      4'h7: hex_pat = 7'h07;
      4'h8: hex_pat = 7'h7F;
      4'h9: hex_pat = 7'h6F;
      4'hA: hex_pat = 7'h77;
      4'hB: hex_pat = 7'h7C;
      4'hC: hex_pat = 7'h39;
      4'hD: hex_pat = 7'h5E;
      4'hE: hex_pat = 7'h79;
      default: hex_pat = 7'h71;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the digit-to-segment encoder: maps a lit-segment
// pattern back to its hex digit, flagging anything outside the glyph table.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic [3:0] digit
);

  // Glyphs are unique, so at most one table entry can match.
  always_comb begin
    legal = 1'b0;
    digit = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seg == hex_pat(4'(i))) begin
        legal = 1'b1;
        digit = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_readback_checker.sv
// Loopback monitor for the 7-segment display: decodes the sampled segment
// lines and checks that the shown digit advances by +1 (mod 16) each tick.
module seg7_readback_checker
  import seg7_pkg::*;
#(
  parameter int ACTIVE_LOW = 1,
  parameter int SYNC_COUNT = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk1s,
  input  logic             reset,
  input  logic [7:0]       seg_n,
  output logic [3:0]       digit,
  output logic             digit_ok,
  output logic             locked,
  output logic             mismatch,
  output logic             restart,
  output logic             dp_seen,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [2:0] SYNC_N = 3'(SYNC_COUNT);

  logic [7:0] seg_q;
  logic       legal;
  logic [3:0] dec;
  logic [3:0] expect_d;
  logic       good;
  state_t     state, state_nxt;
  logic [2:0] step_cnt, cnt_nxt;
  logic       mism_nxt, rst_nxt;

  // Normalise polarity once so everything downstream sees lit = 1.
  always_ff @(posedge clk1s or negedge reset) begin
    if (!reset) seg_q <= 8'h00;
    else        seg_q <= (ACTIVE_LOW != 0) ? ~seg_n : seg_n;
  end

  seg7_decode u_dec (
    .seg   (seg_q[SEG_G:SEG_A]),
    .legal (legal),
    .digit (dec)
  );

  assign expect_d = digit + 4'd1;
  assign good     = legal && (dec == expect_d);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = step_cnt;
    mism_nxt  = 1'b0;
    rst_nxt   = 1'b0;
    case (state)
      HUNT: begin
        if (legal) begin
          state_nxt = SYNC;
          cnt_nxt   = 3'd0;
        end
      end
      SYNC: begin
        if (!legal) begin
          state_nxt = HUNT;
        end else if (good) begin
          if (step_cnt + 3'd1 == SYNC_N) begin
            state_nxt = LOCK;
            cnt_nxt   = 3'd0;
          end else begin
            cnt_nxt = step_cnt + 3'd1;
          end
        end else begin
          cnt_nxt = 3'd0;  // wrong but legal: reseed from this digit
        end
      end
      LOCK: begin
        if (!legal) begin
          mism_nxt  = 1'b1;
          state_nxt = HUNT;
        end else if (!good) begin
          // A jump to 0 is the display counter being reset, not a fault.
          if (dec == 4'h0) rst_nxt  = 1'b1;
          else             mism_nxt = 1'b1;
          state_nxt = SYNC;
          cnt_nxt   = 3'd0;
        end
      end
      default: begin
        state_nxt = HUNT;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk1s or negedge reset) begin
    if (!reset) begin
      state     <= HUNT;
      step_cnt  <= 3'd0;
      digit     <= 4'h0;
      digit_ok  <= 1'b0;
      mismatch  <= 1'b0;
      restart   <= 1'b0;
      dp_seen   <= 1'b0;
      err_count <= '0;
    end else begin
      state    <= state_nxt;
      step_cnt <= cnt_nxt;
      if (legal) digit <= dec;
      digit_ok <= legal;
      mismatch <= mism_nxt;
      restart  <= rst_nxt;
      dp_seen  <= dp_seen | seg_q[SEG_DP];
      if (mism_nxt && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

  assign locked = (state == LOCK);

endmodule

// File: tb/tb_seg7_readback_checker.sv
// Randomised scoreboard bench for seg7_readback_checker against a
// behavioural model of the readback rules.
module tb_seg7_readback_checker;

  logic       clk1s = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] seg_n = 8'hFF;
  logic [3:0] digit;
  logic       digit_ok, locked, mismatch, restart, dp_seen;
  logic [7:0] err_count;

  seg7_readback_checker #(.ACTIVE_LOW(1), .SYNC_COUNT(2), .ERR_W(8)) dut (
    .clk1s     (clk1s),
    .reset     (reset),
    .seg_n     (seg_n),
    .digit     (digit),
    .digit_ok  (digit_ok),
    .locked    (locked),
    .mismatch  (mismatch),
    .restart   (restart),
    .dp_seen   (dp_seen),
    .err_count (err_count)
  );

  always #5 clk1s = ~clk1s;

  typedef struct packed {
    logic [3:0] digit;
    logic       ok, locked, mm, rs, dp;
    logic [7:0] err;
  } exp_t;

  exp_t q[$];
  exp_t stage[$];
  int vectors = 0;
  int miscompares = 0;

  // Model: mode 0 = hunting, 1 = syncing, 2 = locked.
  int         m_mode, m_steps;
  logic [3:0] m_digit;
  logic       m_ok, m_dp;
  int         m_err;

  function automatic logic [6:0] glyph(input int d);
    logic [6:0] tbl [16];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tbl[d % 16];
  endfunction

  task automatic model_reset();
    m_mode = 0; m_steps = 0; m_digit = 0; m_ok = 0; m_dp = 0; m_err = 0;
  endtask

  function automatic exp_t model_step(input logic [7:0] sn);
    logic [7:0] lit;
    int val;
    bit ok, mm, rs;
    int nxt;
    exp_t e;
    lit = ~sn;
    val = -1;
    for (int i = 0; i < 16; i++) if (glyph(i) == lit[6:0]) val = i;
    ok = (val >= 0);
    nxt = (int'(m_digit) + 1) % 16;
    mm = 0; rs = 0;
    m_dp = m_dp | lit[7];
    if (m_mode == 0) begin
      if (ok) begin m_mode = 1; m_steps = 0; end
    end else if (m_mode == 1) begin
      if (!ok) m_mode = 0;
      else if (val == nxt) begin
        m_steps++;
        if (m_steps == 2) begin m_mode = 2; m_steps = 0; end
      end else m_steps = 0;
    end else begin
      if (!ok) begin mm = 1; m_mode = 0; end
      else if (val != nxt) begin
        if (val == 0) rs = 1; else mm = 1;
        m_mode = 1; m_steps = 0;
      end
    end
    if (ok) m_digit = 4'(val);
    m_ok = ok;
    if (mm && m_err < 255) m_err++;
    e.digit = m_digit; e.ok = m_ok; e.locked = (m_mode == 2);
    e.mm = mm; e.rs = rs; e.dp = m_dp; e.err = 8'(m_err);
    return e;
  endfunction

  task automatic drive(input logic [7:0] sn);
    @(negedge clk1s);
    seg_n = sn;
    q.push_back(model_step(sn));
  endtask

  task automatic drive_digit(input int d, input bit dp);
    logic [7:0] v;
    v = {dp, glyph(d)};
    drive(~v);
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: result for a sample driven before edge k appears after edge k+1.
  initial begin
    forever begin
      @(posedge clk1s);
      #1;
      if (!reset) begin
        stage.delete();
      end else begin
        if (stage.size() > 0) begin
          exp_t e;
          e = stage.pop_front();
          vectors++;
          chk("digit",     int'(digit),     int'(e.digit));
          chk("digit_ok",  int'(digit_ok),  int'(e.ok));
          chk("locked",    int'(locked),    int'(e.locked));
          chk("mismatch",  int'(mismatch),  int'(e.mm));
          chk("restart",   int'(restart),   int'(e.rs));
          chk("dp_seen",   int'(dp_seen),   int'(e.dp));
          chk("err_count", int'(err_count), int'(e.err));
        end
        if (q.size() > 0) stage.push_back(q.pop_front());
      end
    end
  end

  task automatic release_reset();
    @(posedge clk1s);
    #2 reset = 1'b1;
  endtask

  initial begin
    int r, rounds;
    model_reset();
    #1;
    vectors++;
    chk("rst_digit",  int'(digit),     0);
    chk("rst_ok",     int'(digit_ok),  0);
    chk("rst_locked", int'(locked),    0);
    chk("rst_err",    int'(err_count), 0);
    release_reset();

    // Count up from 0 through a wrap, then stall, restart and blank display.
    for (int d = 0; d <= 21; d++) drive_digit(d % 16, 0);
    drive_digit(5, 0);
    for (int d = 6; d <= 9; d++) drive_digit(d, 0);
    drive_digit(0, 0);
    for (int d = 1; d <= 3; d++) drive_digit(d, 0);
    drive(8'hFF);
    drive_digit(3, 1);
    drive_digit(4, 0);
    drive_digit(5, 0);

    // Random mix of good steps, stalls, restarts, jumps, junk and dp.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 15);
      if (r < 10)       drive_digit(int'(m_digit) + 1, 0);
      else if (r == 10) drive_digit(int'(m_digit), 0);
      else if (r == 11) drive_digit(0, 0);
      else if (r == 12) drive_digit($urandom_range(0, 15), 0);
      else if (r == 13) drive(8'($urandom_range(0, 255)));
      else if (r == 14) drive(8'hFF);
      else              drive_digit(int'(m_digit) + 1, 1);
    end

    // Drive the error counter into saturation and a bit beyond.
    rounds = 0;
    while (m_err < 255 && rounds < 600) begin
      for (int k = 1; k <= 3; k++) drive_digit(int'(m_digit) + 1, 0);
      drive_digit(int'(m_digit), 0);
      rounds++;
    end
    for (int k = 0; k < 4; k++) begin
      for (int j = 1; j <= 3; j++) drive_digit(int'(m_digit) + 1, 0);
      drive(8'hFF);
    end
    if (m_err < 255) begin
      miscompares++;
      $display("FAIL sat_setup: model err %0d never reached ff", m_err);
    end
    drive_digit(int'(m_digit) + 1, 0);
    drive_digit(int'(m_digit) + 1, 0);

    // Asynchronous reset between edges clears everything at once.
    @(posedge clk1s);
    #3 reset = 1'b0;
    #1;
    vectors++;
    chk("async_digit",    int'(digit),     0);
    chk("async_ok",       int'(digit_ok),  0);
    chk("async_locked",   int'(locked),    0);
    chk("async_mismatch", int'(mismatch),  0);
    chk("async_restart",  int'(restart),   0);
    chk("async_dp",       int'(dp_seen),   0);
    chk("async_err",      int'(err_count), 0);
    q.delete();
    model_reset();
    seg_n = 8'hFF;
    repeat (2) @(posedge clk1s);
    release_reset();
    for (int d = 7; d <= 12; d++) drive_digit(d, 0);
    drive_digit(12, 0);

    repeat (3) @(posedge clk1s);
    #2;
    if (q.size() != 0 || stage.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d results never checked", q.size() + stage.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
